// File: rtl/sram_pkg.sv
// Shared defaults and FSM state encoding for the SRAM burst reader.
package sram_pkg;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_reader_piso.sv
// Parallel-in serial-out shift register; emits bit 0 first and shifts right.
module piso #(
    parameter int COLS = 8
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            load,
    input  logic [COLS-1:0] din,
    input  logic            shift,
    output logic            dout
);

    logic [COLS-1:0] r_sr;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sr <= '0;
        end else if (load) begin
            r_sr <= din;
        end else if (shift) begin
            r_sr <= {1'b0, r_sr[COLS-1:1]};
        end
    end

    assign dout = r_sr[0];

endmodule

// File: rtl/sram_reader.sv
// Burst reader: fetches consecutive SRAM rows (wrapping) and streams each row
// out LSB first under a valid/ready handshake.
module sram_reader
    import sram_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic                       start,
    input  logic [$clog2(ROWS)-1:0]    start_addr,
    input  logic [$clog2(ROWS+1)-1:0]  burst_len,
    input  logic                       abort,
    input  logic                       data_valid,
    input  logic [COLS-1:0]            data_out,
    output logic                       r_en,
    output logic [$clog2(ROWS)-1:0]    addr,
    output logic                       serial_out,
    output logic                       serial_valid,
    input  logic                       serial_ready,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(ROWS);
    localparam int LW = $clog2(ROWS+1);
    localparam int CW = $clog2(COLS+1);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic [LW-1:0]   r_rows;
    logic [CW-1:0]   r_bits;
    logic            w_load;
    logic            w_xfer;
    logic            w_last_bit;
    logic            w_more_rows;
    logic            w_bit0;

    // abort suppresses both the row load and any bit transfer on its edge
    assign w_load      = (r_state == S_READ)  && data_valid   && !abort;
    assign w_xfer      = (r_state == S_SHIFT) && serial_ready && !abort;
    assign w_last_bit  = (r_bits == CW'(COLS-1));
    assign w_more_rows = (r_rows > LW'(1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_READ;
            end
            S_READ: begin
                if (abort)           w_next = S_IDLE;
                else if (data_valid) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_xfer && w_last_bit) begin
                    w_next = w_more_rows ? S_READ : S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_addr <= '0;
            r_rows <= '0;
            r_bits <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_addr <= start_addr;
                r_rows <= (burst_len == '0) ? LW'(ROWS) : burst_len;
            end
            if (w_load) begin
                r_bits <= '0;
            end else if (w_xfer) begin
                r_bits <= r_bits + CW'(1);
                // ROWS is a power of two, so natural overflow wraps the address
                if (w_last_bit && w_more_rows) begin
                    r_rows <= r_rows - LW'(1);
                    r_addr <= r_addr + AW'(1);
                end
            end
        end
    end

    piso #(
        .COLS (COLS)
    ) u_piso (
        .clk   (clk),
        .arst  (arst),
        .load  (w_load),
        .din   (data_out),
        .shift (w_xfer),
        .dout  (w_bit0)
    );

    assign addr         = r_addr;
    assign r_en         = (r_state == S_READ);
    assign serial_valid = (r_state == S_SHIFT);
    assign serial_out   = (r_state == S_SHIFT) && w_bit0;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_sram_reader.sv
// Directed bench for sram_reader with a combinational SRAM model (ROWS=8, COLS=8).
module tb_sram_reader;

    logic       clk = 1'b0;
    logic       arst;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] burst_len;
    logic       abort;
    logic       data_valid;
    logic [7:0] data_out;
    logic       r_en;
    logic [2:0] addr;
    logic       serial_out;
    logic       serial_valid;
    logic       serial_ready;
    logic       busy;
    logic       done;

    logic [7:0] mem [8];

    int n_chk = 0;
    int n_err = 0;

    logic [2:0] cap_addr [$];
    logic [7:0] cap_row  [$];
    int n_ren, n_xfer, n_done, n_cyc, n_unstable;

    always #5 clk = ~clk;

    assign data_valid = r_en;
    assign data_out   = mem[addr];

    sram_reader #(
        .ROWS (8),
        .COLS (8)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .start        (start),
        .start_addr   (start_addr),
        .burst_len    (burst_len),
        .abort        (abort),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .r_en         (r_en),
        .addr         (addr),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .serial_ready (serial_ready),
        .busy         (busy),
        .done         (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] q_addr(input int i);
        return (i < cap_addr.size()) ? 32'(cap_addr[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] q_row(input int i);
        return (i < cap_row.size()) ? 32'(cap_row[i]) : 32'hFFFF_FFFF;
    endfunction

    // md: 0 = ready held high, 1 = ready toggles 1,0,1,0 per row, 2 = ready high plus stray starts
    task automatic burst(input logic [2:0] sa, input logic [3:0] bl, input int md);
        logic [7:0] row;
        int  bi, t, sc;
        bit  pv, pr, pb, fin;
        cap_addr.delete();
        cap_row.delete();
        n_ren = 0; n_xfer = 0; n_done = 0; n_cyc = 0; n_unstable = 0;
        row = '0; bi = 0; t = 0; sc = 0; pv = 0; pr = 0; pb = 0; fin = 0;
        start = 1'b1; start_addr = sa; burst_len = bl;
        @(negedge clk);
        start = 1'b0;
        while (!fin && t < 400) begin
            if (busy) n_cyc++;
            if (r_en) begin
                cap_addr.push_back(addr);
                n_ren++;
                sc = 0;
            end
            serial_ready = (md == 1) ? (sc % 2 == 0) : 1'b1;
            if (serial_valid) begin
                if (pv && !pr && (serial_out != pb)) n_unstable++;
                if (serial_ready) begin
                    row[bi] = serial_out;
                    bi++;
                    n_xfer++;
                    if (bi == 8) begin
                        cap_row.push_back(row);
                        bi = 0;
                    end
                end
                pv = 1; pr = serial_ready; pb = serial_out;
                sc++;
            end else begin
                pv = 0;
            end
            if (md == 2) begin
                start      = busy && (t % 3 == 1);
                start_addr = 3'd5;
                burst_len  = 4'd1;
            end
            if (done) begin
                n_done++;
                fin   = 1;
                start = 1'b0;
            end
            t++;
            @(negedge clk);
        end
        serial_ready = 1'b1;
        if (!fin) chk("burst_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem = '{8'h11, 8'h22, 8'h3C, 8'hA5, 8'h96, 8'h5A, 8'hC3, 8'h7E};
        arst = 1'b1; start = 1'b0; start_addr = '0; burst_len = '0;
        abort = 1'b0; serial_ready = 1'b1;
        #1;
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ren",   32'(r_en), 32'd0);
        chk("rst_sval",  32'(serial_valid), 32'd0);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_addr",  32'(addr), 32'd0);
        @(negedge clk); @(negedge clk);
        arst = 1'b0;
        @(negedge clk);

        // single row 3 = A5, expects bits 1,0,1,0,0,1,0,1
        burst(3'd3, 4'd1, 0);
        chk("t1_nren",  32'(n_ren), 32'd1);
        chk("t1_addr",  q_addr(0), 32'd3);
        chk("t1_row",   q_row(0), 32'h0000_00A5);
        chk("t1_nxfer", 32'(n_xfer), 32'd8);
        chk("t1_ncyc",  32'(n_cyc), 32'd10);
        chk("t1_ndone", 32'(n_done), 32'd1);
        chk("t1_idle",  32'(busy), 32'd0);
        chk("t1_done0", 32'(done), 32'd0);

        // wrap 6,7,0
        burst(3'd6, 4'd3, 0);
        chk("t2_a0",    q_addr(0), 32'd6);
        chk("t2_a1",    q_addr(1), 32'd7);
        chk("t2_a2",    q_addr(2), 32'd0);
        chk("t2_nxfer", 32'(n_xfer), 32'd24);
        chk("t2_r0",    q_row(0), 32'h0000_00C3);
        chk("t2_r1",    q_row(1), 32'h0000_007E);
        chk("t2_r2",    q_row(2), 32'h0000_0011);
        chk("t2_ncyc",  32'(n_cyc), 32'd28);

        // backpressure
        burst(3'd4, 4'd2, 1);
        chk("t3_nxfer", 32'(n_xfer), 32'd16);
        chk("t3_stable", 32'(n_unstable), 32'd0);
        chk("t3_r0",    q_row(0), 32'h0000_0096);
        chk("t3_r1",    q_row(1), 32'h0000_005A);
        chk("t3_ncyc",  32'(n_cyc), 32'd33);

        // burst_len 0 reads every row; stray starts while busy are ignored
        burst(3'd0, 4'd0, 2);
        chk("t4_nren",  32'(n_ren), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_a%0d", i), q_addr(i), 32'(i));
            chk($sformatf("t4_r%0d", i), q_row(i), 32'(mem[i]));
        end
        chk("t4_ndone", 32'(n_done), 32'd1);
        chk("t4_idle",  32'(busy), 32'd0);

        // async reset during the 4th SHIFT cycle of row 2 (3C, bit3 = 1)
        start = 1'b1; start_addr = 3'd2; burst_len = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_pre_sout", 32'(serial_out), 32'd1);
        #1 arst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ren",  32'(r_en), 32'd0);
        chk("t5_sout", 32'(serial_out), 32'd0);
        chk("t5_sval", 32'(serial_valid), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_addr", 32'(addr), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        burst(3'd5, 4'd1, 0);
        chk("t5_post_addr", q_addr(0), 32'd5);
        chk("t5_post_row",  q_row(0), 32'h0000_005A);
        chk("t5_post_done", 32'(n_done), 32'd1);

        // abort during the 2nd SHIFT cycle
        start = 1'b1; start_addr = 3'd1; burst_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_pre_sval", 32'(serial_valid), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_sval", 32'(serial_valid), 32'd0);
        chk("t6_ren",  32'(r_en), 32'd0);
        @(negedge clk);
        chk("t6_done2", 32'(done), 32'd0);
        chk("t6_busy2", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
